banco_reg_sb: RTL

// - Parametrised register bank: 2 async read ports, 1 sync write port, synchronous clear.
// - Per-register busy scoreboard: the issue stage reserves a destination, writeback releases it.
// - Busy flags on both read ports let the decode stage stall on RAW hazards.
// - Sits between decode (read/reserve) and writeback (write) of the single-cycle/pipelined CPU datapath.

---
 rtl/banco_reg_sb_if.sv | 37 +++
 rtl/banco_reg_sb.sv | 92 +++++++++
 2 files changed

// File: rtl/banco_reg_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : banco_reg_sb_if
//  Description : Decode/writeback bus of the register bank with busy
//                scoreboard: two read ports, one write port, one reserve port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface banco_reg_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Reg1;
    logic [ADDR_W-1:0] Reg2;
    logic [DATA_W-1:0] DataReg1;
    logic [DATA_W-1:0] DataReg2;
    logic              Busy1;
    logic              Busy2;
    logic              RegEn;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] Data;
    logic              RsvEn;
    logic [ADDR_W-1:0] RsvAddr;
    logic              AnyBusy;

    // Pipeline side: drives addresses, write and reserve requests.
    modport master (
        output Reg1, Reg2, RegEn, WriteAddr, Data, RsvEn, RsvAddr,
        input  DataReg1, DataReg2, Busy1, Busy2, AnyBusy
    );

    // Register bank side.
    modport slave (
        input  Reg1, Reg2, RegEn, WriteAddr, Data, RsvEn, RsvAddr,
        output DataReg1, DataReg2, Busy1, Busy2, AnyBusy
    );
endinterface
`default_nettype wire

// File: rtl/banco_reg_sb.sv
`default_nettype none
// ============================================================================
//  Module      : banco_reg_sb
//  Description : Register bank (2 async read ports, 1 sync write port,
//                synchronous clear) with a per-register busy scoreboard.
//                Issue reserves a destination, writeback releases it.
//                Optional macro BANCOREG_BYPASS_EN enables write-to-read
//                forwarding of data and busy status in the write cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module banco_reg_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    banco_reg_sb_if.slave   bus
);

    localparam int c_DEPTH   = 1 << ADDR_W;
    localparam bit c_ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;

    // Register 0 is hard-wired when enabled, so its writes and reserves vanish.
    logic w_wr_ok;
    logic w_rsv_ok;
    assign w_wr_ok  = bus.RegEn && !(c_ZERO_EN && (bus.WriteAddr == '0));
    assign w_rsv_ok = bus.RsvEn && !(c_ZERO_EN && (bus.RsvAddr   == '0));

    // Storage: synchronous clear, otherwise the writeback value is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.WriteAddr] <= bus.Data;
        end
    end

    // Scoreboard: the reserve is assigned last so a same-cycle reserve of the
    // written register wins over the release (the new producer is pending).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_busy[bus.WriteAddr] <= 1'b0;
            end
            if (w_rsv_ok) begin
                r_busy[bus.RsvAddr] <= 1'b1;
            end
        end
    end

    // Two identical read ports: data and busy are pure functions of the
    // address and the stored state (plus the live write when forwarding).
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rbusy;

        assign w_raddr = (p == 0) ? bus.Reg1 : bus.Reg2;

        // Read mux with optional forwarding and zero-register override.
        always_comb begin
            w_rdata = r_mem[w_raddr];
            w_rbusy = r_busy[w_raddr];
`ifdef BANCOREG_BYPASS_EN
            if (w_wr_ok && (bus.WriteAddr == w_raddr)) begin
                w_rdata = bus.Data;
                w_rbusy = w_rsv_ok && (bus.RsvAddr == w_raddr);
            end
`endif
            if (c_ZERO_EN && (w_raddr == '0)) begin
                w_rdata = '0;
                w_rbusy = 1'b0;
            end
        end
    end

    assign bus.DataReg1 = g_port[0].w_rdata;
    assign bus.DataReg2 = g_port[1].w_rdata;
    assign bus.Busy1    = g_port[0].w_rbusy;
    assign bus.Busy2    = g_port[1].w_rbusy;
    assign bus.AnyBusy  = |r_busy;

endmodule
`default_nettype wire
